// File: rtl/fp_mul_arb_pkg.sv
// Shared types and constants for the float-multiplier arbiter.
// Holds the arbiter state encoding and the float word width.
// FP_NAN is the canonical quiet NaN the multiplier emits for invalid ops.
package fp_mul_arb_pkg;

   localparam int          FLOAT_W = 32;
   localparam logic [31:0] FP_NAN  = 32'hFFC00000;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEND_A = 3'd1,
      SEND_B = 3'd2,
      WAIT_Z = 3'd3,
      RETURN = 3'd4
   } state_t;

endpackage

// File: rtl/fp_mul_rr_pick.sv
// Purpose: pick one requester from req_stb, round-robin starting at ptr.
// Latency: combinational, zero cycles.
// Backpressure: none; with FP_MUL_ARB_FIXED_PRIO_EN the lowest set index wins and ptr is ignored.
module fp_mul_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_stb,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   winner
);

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Scan downward so the lowest set index is the last one written and wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_stb[i]) begin
            valid  = 1'b1;
            winner = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W:0] sum;

   // Scan offsets downward from ptr so the smallest offset (closest after ptr) wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      sum    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (sum >= (IDX_W + 1)'(NUM_REQ))
            sum = sum - (IDX_W + 1)'(NUM_REQ);
         if (req_stb[sum[IDX_W-1:0]]) begin
            valid  = 1'b1;
            winner = sum[IDX_W-1:0];
         end
      end
   end
`endif

endmodule

// File: rtl/fp_mul_arbiter.sv
// Purpose: share one stb/ack float multiplier among NUM_REQ requesters (FP_MUL_ARB_FIXED_PRIO_EN: fixed priority).
// Latency: 1 arbitration cycle + operand handshakes + multiplier latency + response handshake.
// Backpressure: one op in flight; no new grant until the winner takes rsp via rsp_ack[grant].
module fp_mul_arbiter
   import fp_mul_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ*FLOAT_W-1:0] req_a,
   input  logic [NUM_REQ*FLOAT_W-1:0] req_b,
   input  logic [NUM_REQ-1:0]         req_stb,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic [FLOAT_W-1:0]         rsp_z,
   output logic [NUM_REQ-1:0]         rsp_stb,
   input  logic [NUM_REQ-1:0]         rsp_ack,
   output logic [FLOAT_W-1:0]         mul_a,
   output logic                       mul_a_stb,
   input  logic                       mul_a_ack,
   output logic [FLOAT_W-1:0]         mul_b,
   output logic                       mul_b_stb,
   input  logic                       mul_b_ack,
   input  logic [FLOAT_W-1:0]         mul_z,
   input  logic                       mul_z_stb,
   output logic                       mul_z_ack,
   output logic                       busy,
   output logic [IDX_W-1:0]           grant
);

   state_t           state, state_nxt;
   logic             pick_vld;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] ptr;

   fp_mul_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_stb (req_stb),
      .ptr     (ptr),
      .valid   (pick_vld),
      .winner  (pick_idx)
   );

   // State register; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic and the strobes that follow directly from the state.
   always_comb begin
      state_nxt = state;
      mul_a_stb = 1'b0;
      mul_b_stb = 1'b0;
      mul_z_ack = 1'b0;
      rsp_stb   = '0;
      busy      = (state != IDLE);
      case (state)
         IDLE:   if (pick_vld) state_nxt = SEND_A;
         SEND_A: begin
            mul_a_stb = 1'b1;
            if (mul_a_ack) state_nxt = SEND_B;
         end
         SEND_B: begin
            mul_b_stb = 1'b1;
            if (mul_b_ack) state_nxt = WAIT_Z;
         end
         WAIT_Z: begin
            mul_z_ack = 1'b1;
            if (mul_z_stb) state_nxt = RETURN;
         end
         RETURN: begin
            rsp_stb = NUM_REQ'(1) << grant;
            if (rsp_ack[grant]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture the winner's operands and ack, latch the product, advance the rr pointer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         grant   <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
         req_ack <= '0;
         rsp_z   <= '0;
         ptr     <= '0;
      end else begin
         req_ack <= '0;
         if (state == IDLE && pick_vld) begin
            grant   <= pick_idx;
            mul_a   <= req_a[pick_idx*FLOAT_W +: FLOAT_W];
            mul_b   <= req_b[pick_idx*FLOAT_W +: FLOAT_W];
            req_ack <= NUM_REQ'(1) << pick_idx;
         end
         if (state == WAIT_Z && mul_z_stb)
            rsp_z <= mul_z;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
         if (state == RETURN && rsp_ack[grant]) begin
            if (grant == IDX_W'(NUM_REQ - 1)) ptr <= '0;
            else                              ptr <= grant + 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a small behavioural multiplier.
// Products come from a table of hand-computed IEEE-754 results.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fp_mul_arbiter;
   import fp_mul_arb_pkg::*;

   localparam int N = 4;
   localparam int W = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N*32-1:0]   req_a = '0;
   logic [N*32-1:0]   req_b = '0;
   logic [N-1:0]      req_stb = '0;
   logic [N-1:0]      req_ack;
   logic [31:0]       rsp_z;
   logic [N-1:0]      rsp_stb;
   logic [N-1:0]      rsp_ack = '0;
   logic [31:0]       mul_a, mul_b, mul_z;
   logic              mul_a_stb, mul_b_stb, mul_z_ack;
   logic              mul_a_ack, mul_b_ack, mul_z_stb;
   logic              busy;
   logic [W-1:0]      grant;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   fp_mul_arbiter #(.NUM_REQ(N), .IDX_W(W)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
      .rsp_z(rsp_z), .rsp_stb(rsp_stb), .rsp_ack(rsp_ack),
      .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
      .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
      .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
      .busy(busy), .grant(grant)
   );

   // Hand-computed products for every operand pair used below.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         64'h3FC00000_40000000: fmul = 32'h40400000; // 1.5 * 2.0 = 3.0
         64'h40000000_40400000: fmul = 32'h40C00000; // 2.0 * 3.0 = 6.0
         64'h3F800000_40800000: fmul = 32'h40800000; // 1.0 * 4.0 = 4.0
         64'h40400000_40400000: fmul = 32'h41100000; // 3.0 * 3.0 = 9.0
         64'h40A00000_40000000: fmul = 32'h41200000; // 5.0 * 2.0 = 10.0
         64'h3F000000_40800000: fmul = 32'h40000000; // 0.5 * 4.0 = 2.0
         64'h7F800000_00000000: fmul = FP_NAN;       // inf * 0 = NaN
         default:               fmul = 32'hDEADBEEF;
      endcase
   endfunction

   // Behavioural multiplier: take A, take B, wait 3 cycles, offer Z.
   logic [1:0]  m_st;
   logic [1:0]  m_cnt;
   logic [31:0] m_a, m_b;
   always @(posedge clk) begin
      if (!rst) begin
         m_st <= 0; m_cnt <= 0; m_a <= 0; m_b <= 0;
         mul_a_ack <= 0; mul_b_ack <= 0; mul_z_stb <= 0; mul_z <= 0;
      end else begin
         case (m_st)
            2'd0: begin
               mul_a_ack <= 1'b1;
               if (mul_a_stb && mul_a_ack) begin
                  m_a <= mul_a; mul_a_ack <= 1'b0; m_st <= 2'd1;
               end
            end
            2'd1: begin
               mul_b_ack <= 1'b1;
               if (mul_b_stb && mul_b_ack) begin
                  m_b <= mul_b; mul_b_ack <= 1'b0; m_st <= 2'd2; m_cnt <= 2'd3;
               end
            end
            2'd2: begin
               if (m_cnt == 0) begin
                  mul_z <= fmul(m_a, m_b); mul_z_stb <= 1'b1; m_st <= 2'd3;
               end else m_cnt <= m_cnt - 1'b1;
            end
            default: begin
               if (mul_z_stb && mul_z_ack) begin
                  mul_z_stb <= 1'b0; m_st <= 2'd0;
               end
            end
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic set_pair(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
   endtask

   // Wait for a req_ack pulse, drop that requester's stb, confirm the pulse lasts one cycle.
   task automatic wait_ack(output int idx);
      logic found;
      found = 1'b0;
      idx   = 0;
      for (int c = 0; c < 60 && !found; c++) begin
         @(negedge clk);
         if (req_ack != 0) begin
            found = 1'b1;
            for (int j = 0; j < N; j++) if (req_ack[j]) idx = j;
            req_stb[idx] = 1'b0;
         end
      end
      chk("ack_seen", 32'(found), 32'd1);
      if (found) begin
         @(negedge clk);
         chk("ack_pulse", 32'(req_ack), 32'd0);
      end
   endtask

   task automatic wait_rsp(input int exp_idx, input logic [31:0] exp_z);
      logic found;
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         @(negedge clk);
         if (rsp_stb != 0) found = 1'b1;
      end
      chk("rsp_seen", 32'(found), 32'd1);
      chk("rsp_stb", 32'(rsp_stb), 32'(1 << exp_idx));
      chk("rsp_z", rsp_z, exp_z);
   endtask

   task automatic ack_rsp();
      rsp_ack = rsp_stb;
      @(negedge clk);
      rsp_ack = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   int   idx;
   logic ok_stable, ok_quiet, found;
   logic [31:0] exp_z;

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_rsp_stb", 32'(rsp_stb), 0);
      chk("rst_req_ack", 32'(req_ack), 0);
      chk("rst_mul_a_stb", 32'(mul_a_stb), 0);
      chk("rst_mul_z_ack", 32'(mul_z_ack), 0);
      chk("rst_rsp_z", rsp_z, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single requester 1: 1.5 * 2.0.
      set_pair(1, 32'h3FC00000, 32'h40000000);
      req_stb[1] = 1'b1;
      wait_ack(idx);
      chk("t1_idx", idx, 1);
      chk("t1_grant", 32'(grant), 1);
      chk("t1_mul_a", mul_a, 32'h3FC00000);
      chk("t1_mul_b", mul_b, 32'h40000000);
      wait_rsp(1, 32'h40400000);
      ack_rsp();
      chk("t1_busy_done", 32'(busy), 0);

      // All four requesting: ptr is 2 after serving 1, so reset first to start at 0.
      do_reset();
      set_pair(0, 32'h3F800000, 32'h40800000);
      set_pair(1, 32'h40400000, 32'h40400000);
      set_pair(2, 32'h40A00000, 32'h40000000);
      set_pair(3, 32'h3F000000, 32'h40800000);
      req_stb = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_ack(idx);
         chk("rr4_order", idx, k);
         case (k)
            0: exp_z = 32'h40800000;
            1: exp_z = 32'h41100000;
            2: exp_z = 32'h41200000;
            default: exp_z = 32'h40000000;
         endcase
         wait_rsp(k, exp_z);
         ack_rsp();
      end
      req_stb[0] = 1'b1;
      wait_ack(idx);
      chk("rr_wrap_idx", idx, 0);
      chk("rr_wrap_grant", 32'(grant), 0);
      wait_rsp(0, 32'h40800000);
      ack_rsp();

      // Back-pressure on requester 1 (ptr=1) while 0 and 3 also wait.
      set_pair(1, 32'h3FC00000, 32'h40000000);
      req_stb = 4'b1011;
      wait_ack(idx);
      chk("bp_idx", idx, 1);
      wait_rsp(1, 32'h40400000);
      rsp_ack   = 4'b1101;
      ok_stable = 1'b1;
      ok_quiet  = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rsp_stb !== 4'b0010 || rsp_z !== 32'h40400000) ok_stable = 1'b0;
         if (req_ack !== 0 || mul_a_stb !== 1'b0 || busy !== 1'b1) ok_quiet = 1'b0;
      end
      chk("bp_stable", 32'(ok_stable), 1);
      chk("bp_quiet", 32'(ok_quiet), 1);
      rsp_ack = '0;
      ack_rsp();
      wait_ack(idx);
      chk("bp_next3", idx, 3);
      wait_rsp(3, 32'h40000000);
      ack_rsp();
      wait_ack(idx);
      chk("bp_next0", idx, 0);
      wait_rsp(0, 32'h40800000);
      ack_rsp();

      // Reset during WAIT_Z discards the op.
      set_pair(1, 32'h40000000, 32'h40400000);
      req_stb[1] = 1'b1;
      wait_ack(idx);
      chk("mr_idx", idx, 1);
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         if (mul_z_ack) found = 1'b1;
         else @(negedge clk);
      end
      chk("mr_waitz", 32'(found), 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("mr_busy", 32'(busy), 0);
      chk("mr_req_ack", 32'(req_ack), 0);
      chk("mr_rsp_stb", 32'(rsp_stb), 0);
      chk("mr_rsp_z", rsp_z, 0);
      chk("mr_mul_a_stb", 32'(mul_a_stb), 0);
      chk("mr_mul_b_stb", 32'(mul_b_stb), 0);
      chk("mr_mul_z_ack", 32'(mul_z_ack), 0);
      chk("mr_mul_a", mul_a, 0);
      chk("mr_mul_b", mul_b, 0);
      chk("mr_grant", 32'(grant), 0);
      @(negedge clk);
      req_stb[1] = 1'b1;
      wait_ack(idx);
      chk("mr_again_idx", idx, 1);
      wait_rsp(1, 32'h40C00000);
      ack_rsp();

      // Inf * 0 from requester 2 passes the NaN through untouched.
      set_pair(2, 32'h7F800000, 32'h00000000);
      req_stb[2] = 1'b1;
      wait_ack(idx);
      chk("nan_grant", 32'(grant), 2);
      wait_rsp(2, FP_NAN);
      ack_rsp();

      // Requesters 1 and 3 re-request continuously from ptr=0.
      do_reset();
      set_pair(1, 32'h3FC00000, 32'h40000000);
      set_pair(3, 32'h3F000000, 32'h40800000);
      req_stb = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         wait_ack(idx);
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
         chk("alt_winner", idx, 1);
`else
         chk("alt_winner", idx, (k % 2 == 0) ? 1 : 3);
`endif
         exp_z = (idx == 1) ? 32'h40400000 : 32'h40000000;
         wait_rsp(idx, exp_z);
         rsp_ack      = rsp_stb;
         req_stb[idx] = 1'b1;
         @(negedge clk);
         rsp_ack = '0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one single-precision float multiplier (the stb/ack-handshaked `multiplier` block) between NUM_REQ requesters.
- Accepts an operand pair from the winning requester and sequences the multiplier's get_a/get_b/put_z handshakes.
- Returns the product to the same requester, then re-arbitrates round-robin.
- Sits between the collision-detection compute lanes and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- IDX_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- req_a  in  NUM_REQ*32  operand A per requester; requester i uses bits [32i+31:32i]
- req_b  in  NUM_REQ*32  operand B per requester, same packing
- req_stb  in  NUM_REQ  requester i has a valid operand pair
- req_ack  out  NUM_REQ  one-cycle pulse: pair from requester i consumed
- rsp_z  out  32  product, valid while any rsp_stb bit is set
- rsp_stb  out  NUM_REQ  one-hot: product for requester i is valid
- rsp_ack  in  NUM_REQ  requester i accepts the product
- mul_a  out  32  to multiplier input_a
- mul_a_stb  out  1  to multiplier input_a_stb
- mul_a_ack  in  1  from multiplier input_a_ack
- mul_b  out  32  to multiplier input_b
- mul_b_stb  out  1  to multiplier input_b_stb
- mul_b_ack  in  1  from multiplier input_b_ack
- mul_z  in  32  from multiplier output_z
- mul_z_stb  in  1  from multiplier output_z_stb
- mul_z_ack  out  1  to multiplier output_z_ack
- busy  out  1  FSM not in IDLE
- grant  out  IDX_W  index of the current or last winner

Behaviour:
- Reset (rst==0 at a clk edge):
  - State to IDLE; rr pointer to 0.
  - All outputs 0: req_ack, rsp_stb, rsp_z, mul_*_stb, mul_z_ack, mul_a, mul_b, busy, grant.
  - The rst net is shared with the multiplier, so both restart together; a reset mid-operation discards the transaction without responding.
- Handshake rule, all interfaces: transfer occurs on a clk edge where stb and ack are both 1.
- FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, RETURN.
- IDLE:
  - If req_stb != 0, pick a winner w: the first set bit scanning from ptr upward, wrapping modulo NUM_REQ.
  - Register grant<=w, mul_a<=req_a[w], mul_b<=req_b[w]; pulse req_ack[w]=1 for exactly one cycle; go to SEND_A.
  - Otherwise stay in IDLE.
- SEND_A: mul_a_stb=1. On a cycle with mul_a_stb && mul_a_ack, drop mul_a_stb and go to SEND_B.
- SEND_B: mul_b_stb=1. On a cycle with mul_b_stb && mul_b_ack, drop mul_b_stb and go to WAIT_Z.
- WAIT_Z:
  - mul_z_ack=1 for the whole state; no timeout.
  - On mul_z_stb && mul_z_ack: rsp_z<=mul_z, mul_z_ack<=0, go to RETURN.
- RETURN:
  - rsp_stb[grant]=1, rsp_z held stable.
  - On rsp_ack[grant]: rsp_stb<=0, ptr<=(grant+1) mod NUM_REQ, go to IDLE.
  - rsp_ack bits for other indices are ignored.
- Latency: one cycle of arbitration; total = 1 + multiplier latency + handshake cycles.
- No new grant while busy. req_stb changes in non-IDLE states are ignored; a requester holds stb until it sees its ack.
- Requesters must not reassert stb between req_ack and their rsp_stb (one outstanding op each); a pair is accepted even if stb is lowered later.
- Simultaneous requests are served strictly in round-robin order from ptr. A lone requester is served back-to-back.
- The IEEE result is passed through unmodified; NaN and Inf are not interpreted.

Optional Feature:
- Macro: FP_MUL_ARB_FIXED_PRIO_EN.
- Defined: the winner is always the lowest set index of req_stb, and ptr is unused (held at 0).
- Undefined: round-robin as above.

Decomposition:
- Package fp_mul_arb_pkg holds:
  - the state encoding (3-bit localparams IDLE..RETURN);
  - FLOAT_W=32;
  - FP_NAN=32'hFFC00000, for bench use.
- Sub-module fp_mul_rr_pick: combinational. Inputs req_stb and ptr; outputs valid and winner index. Holds the fixed-priority variant under the macro.

Test Plan:
- Single requester 1: a=0x3FC00000 (1.5), b=0x40000000 (2.0) -> req_ack[1] pulse; later rsp_stb=4'b0010 with rsp_z=0x40400000 (3.0); busy returns to 0.
- All four req_stb high, each with distinct pairs, ptr=0 -> grants in order 0,1,2,3; each rsp_z matches its own pair. Then requester 0 again -> grant 0.
- Back-pressure: hold rsp_ack low for 20 cycles -> rsp_stb and rsp_z stable, no new req_ack and mul_a_stb stays 0, even with other req_stb high.
- Reset mid-operation: drop rst for one cycle during WAIT_Z -> next cycle all outputs 0, state IDLE. A subsequent 2.0*3.0 (0x40000000, 0x40400000) returns 0x40C00000.
- Special value: requester 2 sends 0x7F800000 * 0x00000000 -> rsp_z=0xFFC00000 at rsp_stb[2].
- With FP_MUL_ARB_FIXED_PRIO_EN: req_stb=4'b1010 continuously re-asserted -> requester 1 wins every time; without the macro, winners alternate 1,3,1,3.
